fp_sub_result_buffer: RTL and testbench



---
 rtl/fp_sub_result_buffer.sv | 92 +++++++++
 tb/tb_fp_sub_result_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fp_sub_result_buffer.sv
// Elastic FIFO stage behind the FP subtractor, with sticky status flags and a saturating result count.
// Optional build macro FP_SUB_RES_FLUSH_TINY_EN: tiny results are stored as signed zero with zero/inexact flags set.
module fp_sub_result_buffer #(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16,
  localparam int W        = sig_width + exp_width + 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int LW       = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_z,
  input  logic [7:0]       in_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_z,
  output logic [7:0]       out_status,
  output logic [7:0]       sticky_status,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] result_cnt,
  output logic [LW-1:0]    level
);

  typedef struct packed {
    logic [W-1:0] z;
    logic [7:0]   status;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          entry_in;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   cnt;
  logic            push, pop;

  assign level     = cnt;
  assign in_ready  = (cnt != LW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is gated so an empty buffer shows zeros even though storage keeps stale data.
  assign out_z      = out_valid ? mem[rd_ptr].z      : '0;
  assign out_status = out_valid ? mem[rd_ptr].status : '0;

  always_comb begin
    entry_in.z      = in_z;
    entry_in.status = in_status;
`ifdef FP_SUB_RES_FLUSH_TINY_EN
    if (in_status[3]) begin
      entry_in.z      = {in_z[W-1], {(W-1){1'b0}}};
      entry_in.status = in_status | 8'h21;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Clear wins over accumulation; a push in the clear cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_status <= '0;
      result_cnt    <= '0;
    end else begin
      if (sticky_clr) sticky_status <= push ? entry_in.status : 8'h00;
      else            sticky_status <= sticky_status | (push ? entry_in.status : 8'h00);
      if (push && (result_cnt != '1)) result_cnt <= result_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_sub_result_buffer.sv
// Randomized bench for fp_sub_result_buffer against a queue-based reference model.
module tb_fp_sub_result_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, sticky_clr;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [31:0] out_z, out_z4;
  logic [7:0]  out_status, sticky_status, out_status4, sticky_status4;
  logic [15:0] result_cnt;
  logic [3:0]  result_cnt4;
  logic [2:0]  level, level4;

  fp_sub_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .in_status(in_status), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_status(out_status), .sticky_status(sticky_status), .sticky_clr(sticky_clr),
    .result_cnt(result_cnt), .level(level));

  fp_sub_result_buffer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_z(in_z),
    .in_status(in_status), .out_valid(out_valid4), .out_ready(out_ready), .out_z(out_z4),
    .out_status(out_status4), .sticky_status(sticky_status4), .sticky_clr(sticky_clr),
    .result_cnt(result_cnt4), .level(level4));

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // reference model
  logic [39:0] q[$];
  logic [7:0]  m_sticky;
  int          m_pushes;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] xform(input logic [31:0] z, input logic [7:0] st);
`ifdef FP_SUB_RES_FLUSH_TINY_EN
    if (st[3]) return {z[31], 31'd0, st | 8'h21};
`endif
    return {z, st};
  endfunction

  task automatic check_outputs();
    chk("in_ready",  in_ready,  q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() > 0);
    chk("level",     level,     q.size());
    chk("sticky",    sticky_status, m_sticky);
    chk("result_cnt", result_cnt, (m_pushes > 65535) ? 65535 : m_pushes);
    chk("result_cnt4", result_cnt4, (m_pushes > 15) ? 15 : m_pushes);
    chk("out_z",      out_z,      q.size() > 0 ? q[0][39:8] : 32'd0);
    chk("out_status", out_status, q.size() > 0 ? q[0][7:0]  : 8'd0);
  endtask

  // Called at a falling edge: check, drive, clock, advance model, return at next falling edge.
  task automatic step(input logic v, input logic [31:0] z, input logic [7:0] st,
                      input logic rdy, input logic clr);
    logic        do_push, do_pop;
    logic [39:0] e;
    check_outputs();
    in_valid = v; in_z = z; in_status = st; out_ready = rdy; sticky_clr = clr;
    do_push = v && (q.size() < DEPTH);
    do_pop  = rdy && (q.size() > 0);
    e = xform(z, st);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin q.push_back(e); m_pushes++; end
    if (clr) m_sticky = do_push ? e[7:0] : 8'h00;
    else if (do_push) m_sticky = m_sticky | e[7:0];
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete(); m_sticky = 8'h00; m_pushes = 0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_z = 0; in_status = 0; out_ready = 0; sticky_clr = 0;
    model_reset();
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_level", level, 3'd0);
    @(negedge clk); rst_n = 1'b1;

    // fill to full, then an extra offer, then drain
    for (int i = 0; i < 5; i++) step(1, 32'h1000_0000 + i, 8'h00, 0, 0);
    chk("full_level", level, 3'd4);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 8'h00, 1, 0);

    // streaming
    for (int i = 0; i < 8; i++) step(1, 32'h3F80_0000 + 32'(i) * 32'h0080_0000, 8'h00, 1, 0);
    step(0, 0, 0, 1, 0);

    // sticky accumulate then clear-with-push
    step(0, 0, 8'h00, 1, 1);
    step(1, 32'h1, 8'h20, 1, 0);
    step(1, 32'h2, 8'h01, 1, 0);
    step(1, 32'h3, 8'h04, 1, 0);
    chk("sticky_acc", sticky_status, 8'h25);
    step(1, 32'h4, 8'h10, 1, 1);
    chk("sticky_clr_push", sticky_status, 8'h10);
    step(0, 0, 0, 1, 0);

    // tiny-result flush
    step(1, 32'h8000_0001, 8'h08, 0, 0);
`ifdef FP_SUB_RES_FLUSH_TINY_EN
    chk("flush_z", out_z, 32'h8000_0000);
    chk("flush_st", out_status, 8'h29);
`else
    chk("flush_z", out_z, 32'h8000_0001);
    chk("flush_st", out_status, 8'h08);
`endif
    step(0, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));

    // asynchronous reset with three entries held
    step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 32'hA000_0000 + i, 8'h02, 0, 0);
    chk("pre_rst_level", level, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_level", level, 3'd0);
    chk("mid_rst_sticky", sticky_status, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    step(1, 32'h4049_0FDB, 8'h00, 0, 0);
    chk("post_rst_z", out_z, 32'h4049_0FDB);

    // counter saturation at CNT_W=4
    for (int i = 0; i < 20; i++) step(1, $urandom, 8'h00, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("sat_cnt4", result_cnt4, 4'd15);
    chk("cnt16", result_cnt, 16'd21);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
